// File: rtl/dmem_unit_pkg.sv
// Shared encodings for the data memory: access-width controls and clear/ready FSM states.
package dmem_unit_pkg;

    typedef enum logic [2:0] {
        DM_WORD            = 3'b000,
        DM_HALFWORD        = 3'b001,
        DM_HALFWORD_UNSIGNED = 3'b010,
        DM_BYTE            = 3'b011,
        DM_BYTE_UNSIGNED   = 3'b100
    } dm_ctrl_e;

    typedef enum logic {
        DMEM_CLEAR = 1'b0,
        DMEM_READY = 1'b1
    } dmem_state_e;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatter: store byte enables and lane-replicated write data, load
// extraction with sign/zero extension, and misalignment detection.
module dmem_lane_fmt
    import dmem_unit_pkg::*;
(
    input  logic [2:0]  dm_ctrl_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] din_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_data_o,
    output logic        misalign_o
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign shifted  = rdata_i >> {addr_lo_i, 3'b000};
    assign byte_sel = shifted[7:0];
    assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        be_o       = 4'hF;
        wdata_o    = din_i;
        ld_data_o  = rdata_i;
        misalign_o = 1'b0;
        case (dm_ctrl_i)
            DM_HALFWORD, DM_HALFWORD_UNSIGNED: begin
                misalign_o = addr_lo_i[0];
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{din_i[15:0]}};
                ld_data_o  = (dm_ctrl_i == DM_HALFWORD) ? {{16{half_sel[15]}}, half_sel}
                                                        : {16'h0000, half_sel};
            end
            DM_BYTE, DM_BYTE_UNSIGNED: begin
                be_o      = 4'b0001 << addr_lo_i;
                wdata_o   = {4{din_i[7:0]}};
                ld_data_o = (dm_ctrl_i == DM_BYTE) ? {{24{byte_sel[7]}}, byte_sel}
                                                   : {24'h000000, byte_sel};
            end
            // Word and the reserved encodings
            default: begin
                misalign_o = (addr_lo_i != 2'b00);
            end
        endcase
        if (misalign_o) begin
            be_o      = 4'h0;
            ld_data_o = 32'h0;
        end
    end

endmodule

// File: rtl/dmem_unit.sv
// Data memory behind the MEM stage: byte-lane array with combinational read,
// plus a sequencer that zeroes every word after reset before accepting accesses.
module dmem_unit
    import dmem_unit_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_w,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic [2:0]  dm_ctrl,
    output logic [31:0] dout,
    output logic        busy,
    output logic        misalign
);

    dmem_state_e       state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    logic [ADDR_W-1:0] rd_idx, wr_idx;
    logic [3:0]        fmt_be, wr_be;
    logic [31:0]       fmt_wdata, wr_data, raw_word, fmt_ld;
    logic              fmt_mis;
    logic              unused_addr_bits;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= DMEM_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            DMEM_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == ADDR_W'(DEPTH - 1)) state_d = DMEM_READY;
            end
            DMEM_READY: state_d = DMEM_READY;
            default:    state_d = DMEM_CLEAR;
        endcase
    end

    // Reset is folded in so busy is already high before the first reset edge.
    assign busy = !rst || (state_q == DMEM_CLEAR);

    assign rd_idx           = addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{addr[31:ADDR_W+2]};
    assign wr_idx           = (state_q == DMEM_CLEAR) ? clr_cnt_q : rd_idx;

    always_comb begin
        wr_be   = 4'h0;
        wr_data = fmt_wdata;
        if (rst) begin
            if (state_q == DMEM_CLEAR) begin
                wr_be   = 4'hF;
                wr_data = 32'h0;
            end else if (mem_w) begin
                wr_be = fmt_be;
            end
        end
    end

    dmem_lane_fmt u_lane_fmt (
        .dm_ctrl_i  (dm_ctrl),
        .addr_lo_i  (addr[1:0]),
        .din_i      (din),
        .rdata_i    (raw_word),
        .be_o       (fmt_be),
        .wdata_o    (fmt_wdata),
        .ld_data_o  (fmt_ld),
        .misalign_o (fmt_mis)
    );

    // One byte-wide array per lane keeps each lane's writes in a single process.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_q [DEPTH];

            always_ff @(posedge clk) begin
                if (wr_be[gi]) mem_q[wr_idx] <= wr_data[gi*8 +: 8];
            end

            assign raw_word[gi*8 +: 8] = mem_q[rd_idx];
        end
    endgenerate

    assign dout     = busy ? 32'h0 : fmt_ld;
    assign misalign = busy ? 1'b0  : fmt_mis;

endmodule

// File: tb/tb_dmem_unit.sv
// Directed self-checking bench for dmem_unit: clear sequencing, lane stores,
// extended loads, misalignment, read-before-write and address aliasing.
module tb_dmem_unit;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_w = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] din = 32'h0;
    logic [2:0]  dm_ctrl = 3'b000;
    logic [31:0] dout;
    logic        busy;
    logic        misalign;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] W  = 3'b000;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] HU = 3'b010;
    localparam logic [2:0] B  = 3'b011;
    localparam logic [2:0] BU = 3'b100;

    dmem_unit #(.DEPTH(DEPTH), .ADDR_W(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_w    (mem_w),
        .addr     (addr),
        .din      (din),
        .dm_ctrl  (dm_ctrl),
        .dout     (dout),
        .busy     (busy),
        .misalign (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one access just after a rising edge; outputs are sampled 1 ns later.
    task automatic access(input logic we, input logic [2:0] ctrl,
                          input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        mem_w   = we;
        dm_ctrl = ctrl;
        addr    = a;
        din     = d;
        #1;
        $display("access we=%0d ctrl=%0d addr=%h din=%h -> dout=%h busy=%0d misalign=%0d",
                 we, ctrl, a, d, dout, busy, misalign);
    endtask

    task automatic hold_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
        end
    endtask

    task automatic release_and_count(output int n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        n = 0;
        while (busy && n < DEPTH + 16) begin
            @(posedge clk);
            #1;
            n++;
        end
        $display("clear finished after %0d cycles", n);
    endtask

    initial begin
        int n;
        int nonzero;

        // Reset and first clear
        rst = 1'b0;
        hold_reset(3);
        addr = 32'h3;
        #1;
        check("rst_busy", {31'b0, busy}, 32'd1);
        check("rst_dout", dout, 32'h0);
        check("rst_misalign", {31'b0, misalign}, 32'd0);
        release_and_count(n);
        check("clear_len", n, DEPTH);

        // Preload some words, then re-clear and sweep
        access(1'b1, W, 32'h0, 32'hFFFF_FFFF);
        access(1'b1, W, 32'h14, 32'hFFFF_FFFF);
        access(1'b1, W, 32'hFFC, 32'hFFFF_FFFF);
        access(1'b0, W, 32'hFFC, 32'h0);
        check("preload", dout, 32'hFFFF_FFFF);
        hold_reset(3);
        release_and_count(n);
        check("reclear_len", n, DEPTH);
        nonzero = 0;
        for (int i = 0; i < DEPTH; i++) begin
            @(posedge clk);
            #1;
            mem_w = 1'b0; dm_ctrl = W; addr = 32'(i * 4);
            #1;
            if (dout !== 32'h0) nonzero++;
        end
        check("sweep_nonzero_words", nonzero, 0);

        // Byte store into a word, signed/unsigned byte loads
        access(1'b1, W, 32'h10, 32'h1122_3344);
        access(1'b1, B, 32'h11, 32'h1234_56AA);
        access(1'b0, W, 32'h10, 32'h0);
        check("sb_lw", dout, 32'h1122_AA44);
        access(1'b0, B, 32'h11, 32'h0);
        check("lb", dout, 32'hFFFF_FFAA);
        access(1'b0, BU, 32'h11, 32'h0);
        check("lbu", dout, 32'h0000_00AA);

        // Halfword store on the upper half
        access(1'b1, H, 32'h22, 32'hDEAD_8001);
        access(1'b0, H, 32'h22, 32'h0);
        check("lh", dout, 32'hFFFF_8001);
        access(1'b0, HU, 32'h22, 32'h0);
        check("lhu", dout, 32'h0000_8001);
        access(1'b0, W, 32'h20, 32'h0);
        check("lw_after_sh", dout, 32'h8001_0000);
        access(1'b0, H, 32'h20, 32'h0);
        check("lh_low", dout, 32'h0);
        access(1'b0, B, 32'h23, 32'h0);
        check("lb_top", dout, 32'hFFFF_FF80);

        // Misaligned accesses
        access(1'b1, W, 32'h13, 32'hDEAD_BEEF);
        check("sw_mis_flag", {31'b0, misalign}, 32'd1);
        access(1'b1, H, 32'h21, 32'h0000_7777);
        check("sh_mis_flag", {31'b0, misalign}, 32'd1);
        access(1'b0, W, 32'h10, 32'h0);
        check("mis_w10", dout, 32'h1122_AA44);
        check("aligned_flag", {31'b0, misalign}, 32'd0);
        access(1'b0, W, 32'h20, 32'h0);
        check("mis_w20", dout, 32'h8001_0000);
        access(1'b0, W, 32'h13, 32'h0);
        check("lw_mis_flag", {31'b0, misalign}, 32'd1);
        check("lw_mis_dout", dout, 32'h0);
        access(1'b0, HU, 32'h21, 32'h0);
        check("lhu_mis_dout", dout, 32'h0);
        access(1'b0, BU, 32'h13, 32'h0);
        check("lbu_odd_ok", dout, 32'h0000_0011);
        check("lbu_odd_flag", {31'b0, misalign}, 32'd0);
        access(1'b0, 3'b101, 32'h12, 32'h0);
        check("rsvd_mis_flag", {31'b0, misalign}, 32'd1);

        // Stores during clear are ignored; reset mid-clear restarts it
        hold_reset(3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            access(1'b1, W, 32'h40, 32'h5);
        end
        check("clear_busy", {31'b0, busy}, 32'd1);
        check("clear_dout", dout, 32'h0);
        access(1'b1, W, 32'h41, 32'h5);
        check("clear_misalign", {31'b0, misalign}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        access(1'b1, W, 32'h40, 32'h5);
        release_and_count(n);
        check("restart_len", n, DEPTH);
        mem_w = 1'b0;
        access(1'b0, W, 32'h40, 32'h0);
        check("clear_store_ignored", dout, 32'h0);

        // Read-before-write and address aliasing
        access(1'b1, W, 32'h0, 32'h0123_4567);
        access(1'b1, W, 32'h0, 32'hCAFE_0000);
        check("rbw_old", dout, 32'h0123_4567);
        access(1'b0, W, 32'h0, 32'h0);
        check("rbw_new", dout, 32'hCAFE_0000);
        access(1'b1, W, 32'(DEPTH * 4), 32'hBEEF_0001);
        access(1'b0, W, 32'h0, 32'h0);
        check("alias_word0", dout, 32'hBEEF_0001);
        access(1'b0, 3'b111, 32'h0, 32'h0);
        check("rsvd_as_word", dout, 32'hBEEF_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
